// File: rtl/neuron_argmax_pkg.sv
// -----------------------------------------------------------------------------
// neuron_argmax_pkg
// Project-wide sizing shared between the neuron layer and the argmax stage.
//   OUTPUT_WIDTH : neuron score width, signed Q8.18
//   NUM_NEURONS  : number of neurons in the output layer
//   CLASS_WIDTH  : width of a neuron index (2**CLASS_WIDTH >= NUM_NEURONS)
// -----------------------------------------------------------------------------
package neuron_argmax_pkg;

   localparam int OUTPUT_WIDTH = 26;
   localparam int NUM_NEURONS  = 10;
   localparam int CLASS_WIDTH  = 4;

endpackage : neuron_argmax_pkg

// File: rtl/neuron_argmax_score_compare.sv
// -----------------------------------------------------------------------------
// score_compare
// Combinational signed strictly-greater comparator for neuron scores.
//   a_i  : candidate score (two's complement)
//   b_i  : current best score (two's complement)
//   gt_o : 1 when a_i > b_i as signed values; equal scores give 0
// -----------------------------------------------------------------------------
module score_compare
   import neuron_argmax_pkg::*;
#(
   parameter int WIDTH = OUTPUT_WIDTH
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             gt_o
);

   // Both operands share one width, so the compare is exact with no
   // sign extension or overflow to worry about.
   assign gt_o = $signed(a_i) > $signed(b_i);

endmodule : score_compare

// File: rtl/neuron_argmax.sv
// -----------------------------------------------------------------------------
// neuron_argmax
// Picks the neuron with the largest signed score once every neuron reports
// done. Scores are snapshotted on the capture edge and scanned one per cycle,
// so the result is immune to input changes after capture.
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   IN_SCORES  : packed scores, neuron k at [k*OUTPUT_WIDTH +: OUTPUT_WIDTH]
//   IN_DONE    : per-neuron done levels; capture on a fresh all-ones pattern
//   CLASS      : index of the winning neuron (held until the next result)
//   MAX_SCORE  : winning score (held until the next result)
//   valid      : one-cycle pulse, NUM_NEURONS edges after the capture edge
//   busy       : high while a comparison is in progress
// -----------------------------------------------------------------------------
module neuron_argmax #(
   parameter int NUM_NEURONS  = neuron_argmax_pkg::NUM_NEURONS,
   parameter int OUTPUT_WIDTH = neuron_argmax_pkg::OUTPUT_WIDTH,
   parameter int CLASS_WIDTH  = neuron_argmax_pkg::CLASS_WIDTH
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [NUM_NEURONS*OUTPUT_WIDTH-1:0] IN_SCORES,
   input  logic [NUM_NEURONS-1:0]              IN_DONE,
   output logic [CLASS_WIDTH-1:0]              CLASS,
   output logic [OUTPUT_WIDTH-1:0]             MAX_SCORE,
   output logic                                valid,
   output logic                                busy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam logic [CLASS_WIDTH-1:0] LAST_IDX = CLASS_WIDTH'(NUM_NEURONS - 1);

   state_e                  state_q;
   logic [OUTPUT_WIDTH-1:0] bank_q [NUM_NEURONS];
   logic [OUTPUT_WIDTH-1:0] best_score_q;
   logic [CLASS_WIDTH-1:0]  best_idx_q;
   logic [CLASS_WIDTH-1:0]  ptr_q;
   logic                    armed_q;
   logic [CLASS_WIDTH-1:0]  class_q;
   logic [OUTPUT_WIDTH-1:0] max_score_q;
   logic                    valid_q;
   logic                    busy_q;

   logic                    all_done;
   logic [OUTPUT_WIDTH-1:0] cand_score;
   logic                    cand_gt;

   assign all_done   = &IN_DONE;
   assign cand_score = bank_q[ptr_q];

   score_compare #(
      .WIDTH (OUTPUT_WIDTH)
   ) u_score_compare (
      .a_i  (cand_score),
      .b_i  (best_score_q),
      .gt_o (cand_gt)
   );

   // NOTE: all state uses non-blocking assignments so every register samples
   // the pre-edge values, independent of statement order in this block.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         // NOTE: the score bank is reset on purpose; a comparison aborted by
         // reset must never leave stale scores behind.
         for (int k = 0; k < NUM_NEURONS; k++) begin
            bank_q[k] <= '0;
         end
         best_score_q <= '0;
         best_idx_q   <= '0;
         ptr_q        <= '0;
         armed_q      <= 1'b0;
         class_q      <= '0;
         max_score_q  <= '0;
         valid_q      <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         valid_q <= 1'b0;

         // Any incomplete done pattern re-arms; the capture below clears it
         // and can only fire while all_done is high, so the two never collide.
         if (!all_done) begin
            armed_q <= 1'b1;
         end

         case (state_q)
            ST_IDLE: begin
               if (all_done && armed_q) begin
                  for (int k = 0; k < NUM_NEURONS; k++) begin
                     bank_q[k] <= IN_SCORES[k*OUTPUT_WIDTH +: OUTPUT_WIDTH];
                  end
                  best_score_q <= IN_SCORES[0 +: OUTPUT_WIDTH];
                  best_idx_q   <= '0;
                  ptr_q        <= CLASS_WIDTH'(1);
                  armed_q      <= 1'b0;
                  busy_q       <= 1'b1;
                  state_q      <= ST_SCAN;
               end
            end

            ST_SCAN: begin
               // Strictly greater only: on equal scores the earlier index stays.
               if (cand_gt) begin
                  best_score_q <= cand_score;
                  best_idx_q   <= ptr_q;
               end
               ptr_q <= ptr_q + CLASS_WIDTH'(1);
               if (ptr_q == LAST_IDX) begin
                  state_q <= ST_DONE;
               end
            end

            ST_DONE: begin
               class_q     <= best_idx_q;
               max_score_q <= best_score_q;
               valid_q     <= 1'b1;
               busy_q      <= 1'b0;
               ptr_q       <= '0;
               state_q     <= ST_IDLE;
            end

            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign CLASS     = class_q;
   assign MAX_SCORE = max_score_q;
   assign valid     = valid_q;
   assign busy      = busy_q;

endmodule : neuron_argmax

// File: tb/tb_neuron_argmax.sv
// -----------------------------------------------------------------------------
// tb_neuron_argmax
// Scenario tasks drive score sets into neuron_argmax; expected results are
// queued at capture time and popped when the valid pulse appears.
// -----------------------------------------------------------------------------
module tb_neuron_argmax;

   localparam int N = 10;
   localparam int W = 26;
   localparam int C = 4;

   typedef struct {
      logic [C-1:0] cls;
      logic [W-1:0] mx;
   } exp_t;

   logic           clk = 1'b0;
   logic           rst;
   logic [N*W-1:0] in_scores;
   logic [N-1:0]   in_done;
   logic [C-1:0]   class_o;
   logic [W-1:0]   max_o;
   logic           valid;
   logic           busy;

   logic [W-1:0]   sc [N];
   exp_t           sb [$];
   int             total = 0;
   int             bad = 0;
   int             valid_count = 0;

   neuron_argmax #(
      .NUM_NEURONS  (N),
      .OUTPUT_WIDTH (W),
      .CLASS_WIDTH  (C)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .IN_SCORES (in_scores),
      .IN_DONE   (in_done),
      .CLASS     (class_o),
      .MAX_SCORE (max_o),
      .valid     (valid),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (valid === 1'b1) valid_count++;
   end

   // Reference argmax: first index holding the largest signed score.
   function automatic exp_t model();
      exp_t e;
      e.cls = '0;
      e.mx  = sc[0];
      for (int k = 1; k < N; k++) begin
         if ($signed(sc[k]) > $signed(e.mx)) begin
            e.cls = C'(k);
            e.mx  = sc[k];
         end
      end
      return e;
   endfunction

   task automatic apply_scores();
      for (int k = 0; k < N; k++) in_scores[k*W +: W] = sc[k];
   endtask

   // One cycle of lowpat (arms), then all ones (capture). Returns 1 after the
   // capture edge.
   task automatic do_capture(input logic [N-1:0] lowpat, input bit push);
      apply_scores();
      in_done = lowpat;
      @(posedge clk); #1;
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL partial_done: busy=%0b required 0 (IN_DONE=%h)", busy, lowpat);
      end
      if (push) sb.push_back(model());
      in_done = '1;
      @(posedge clk); #1;
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL capture: busy=%0b required 1", busy);
      end
   endtask

   task automatic wait_result(input string name, input bit scramble);
      exp_t e;
      int   lat = 0;
      for (int i = 1; i <= 3*N && lat == 0; i++) begin
         if (scramble) begin
            for (int k = 0; k < N; k++) in_scores[k*W +: W] = W'($urandom);
         end
         @(posedge clk); #1;
         if (valid === 1'b1) lat = i;
      end
      total++;
      if (sb.size() == 0) begin
         bad++;
         $display("FAIL %s_scoreboard: result with no expectation queued", name);
         return;
      end
      e = sb.pop_front();
      if (lat == 0) begin
         bad++;
         $display("FAIL %s_timeout: no valid within %0d cycles", name, 3*N);
         return;
      end
      if (lat != N) begin
         bad++;
         $display("FAIL %s_latency: got %0d edges, required %0d", name, lat, N);
      end
      total++;
      if (class_o !== e.cls) begin
         bad++;
         $display("FAIL %s_class: got %0d required %0d", name, class_o, e.cls);
      end
      total++;
      if (max_o !== e.mx) begin
         bad++;
         $display("FAIL %s_max: got %h required %h", name, max_o, e.mx);
      end
      @(posedge clk); #1;
      total++;
      if (valid !== 1'b0 || busy !== 1'b0 || class_o !== e.cls) begin
         bad++;
         $display("FAIL %s_after: valid=%0b busy=%0b class=%0d required 0 0 %0d",
                  name, valid, busy, class_o, e.cls);
      end
   endtask

   task automatic test_reset();
      total++;
      if (class_o !== '0 || max_o !== '0 || valid !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_outputs: class=%0d max=%h valid=%0b busy=%0b required all 0",
                  class_o, max_o, valid, busy);
      end
      rst = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      total++;
      if (busy !== 1'b0 || valid_count != 0) begin
         bad++;
         $display("FAIL reset_no_capture: busy=%0b pulses=%0d required 0 0", busy, valid_count);
      end
   endtask

   task automatic test_ramp();
      for (int k = 0; k < N; k++) sc[k] = W'(k * 32'h40000);
      do_capture('0, 1'b1);
      wait_result("ramp", 1'b0);
      total++;
      if (class_o !== 4'd9 || max_o !== 26'h0240000) begin
         bad++;
         $display("FAIL ramp_const: class=%0d max=%h required 9 0240000", class_o, max_o);
      end
   endtask

   task automatic test_signed();
      for (int k = 0; k < N; k++) sc[k] = 26'h3F80000;
      sc[3] = 26'h3FC0000;
      sc[7] = 26'h3FE0000;
      do_capture('0, 1'b1);
      wait_result("signed", 1'b0);
      total++;
      if (class_o !== 4'd7 || max_o !== 26'h3FE0000) begin
         bad++;
         $display("FAIL signed_const: class=%0d max=%h required 7 3fe0000", class_o, max_o);
      end
   endtask

   task automatic test_tie();
      for (int k = 0; k < N; k++) sc[k] = W'(k);
      sc[2] = 26'h1FFFFFF;
      sc[5] = 26'h1FFFFFF;
      do_capture(10'h155, 1'b1);
      wait_result("tie", 1'b0);
      total++;
      if (class_o !== 4'd2 || max_o !== 26'h1FFFFFF) begin
         bad++;
         $display("FAIL tie_const: class=%0d max=%h required 2 1ffffff", class_o, max_o);
      end
   endtask

   task automatic test_retrigger();
      int v0 = valid_count;
      in_done = '1;
      repeat (30) @(posedge clk);
      #1;
      total++;
      if (valid_count != v0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL retrigger_steady: pulses=%0d busy=%0b required %0d 0",
                  valid_count, busy, v0);
      end
      do_capture(10'h1FF, 1'b1);
      wait_result("retrigger", 1'b0);
      total++;
      if (valid_count != v0 + 1) begin
         bad++;
         $display("FAIL retrigger_count: pulses=%0d required %0d", valid_count, v0 + 1);
      end
   endtask

   task automatic test_scan_change();
      for (int k = 0; k < N; k++) sc[k] = W'($urandom) & 26'h1FFFFFE;
      sc[6] = 26'h1FFFFFF;
      do_capture('0, 1'b1);
      wait_result("scan_change", 1'b1);
   endtask

   task automatic test_reset_mid();
      int v0;
      for (int k = 0; k < N; k++) sc[k] = W'(k * 32'h40000);
      do_capture('0, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      v0 = valid_count;
      rst = 1'b1;
      #1;
      total++;
      if (class_o !== '0 || max_o !== '0 || busy !== 1'b0 || valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid: class=%0d max=%h busy=%0b valid=%0b required all 0",
                  class_o, max_o, busy, valid);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      total++;
      if (valid_count != v0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_stuck_done: pulses=%0d busy=%0b required %0d 0",
                  valid_count, busy, v0);
      end
      do_capture('0, 1'b1);
      wait_result("after_reset", 1'b0);
   endtask

   task automatic test_random();
      logic [N-1:0] pat;
      for (int r = 0; r < 6; r++) begin
         for (int k = 0; k < N; k++) sc[k] = W'($urandom);
         pat = N'($urandom);
         pat[$urandom_range(0, N-1)] = 1'b0;
         do_capture(pat, 1'b1);
         wait_result("random", 1'b0);
      end
   endtask

   initial begin
      rst       = 1'b1;
      in_done   = '1;
      in_scores = '0;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_ramp();
      test_signed();
      test_tie();
      test_retrigger();
      test_scan_change();
      test_reset_mid();
      test_random();
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_leftover: %0d entries required 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_neuron_argmax
